// File: rtl/clock_group_reset_sequencer.sv
// ---------------------------------------------------------------------------
// clock_group_reset_sequencer
//
// Produces the reset for one member of a clock group. The asynchronous
// active-low reset is released through a SYNC_STAGES-deep synchronizer. The
// member reset is then held for a further STRETCH_CYCLES cycles before the
// group enters RUN. While in RUN, software can request a member reset. That
// request replays the stretch period and ends with a one-cycle
// acknowledgement.
//
// Parameters
//   SYNC_STAGES     reset-release synchronizer depth (2..8)
//   STRETCH_CYCLES  cycles the member reset is held after release (1..1024)
//
// Ports
//   clock                    in   single clock for every flop; also the member clock
//   reset                    in   asynchronous reset, active low
//   sw_reset_req             in   level request for a software member reset
//   sw_reset_ack             out  one-cycle pulse on the first RUN cycle after a
//                                 software reset
//   auto_out_member_0_clock  out  member clock, passed straight through from clock
//   auto_out_member_0_reset  out  member reset, active high, registered
//   reset_done               out  high while the sequencer is in RUN
// ---------------------------------------------------------------------------
module clock_group_reset_sequencer #(
  parameter int SYNC_STAGES    = 3,
  parameter int STRETCH_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_reset_req,
  output logic sw_reset_ack,
  output logic auto_out_member_0_clock,
  output logic auto_out_member_0_reset,
  output logic reset_done
);

  localparam int              CNT_W    = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2,
    SWRST   = 2'd3
  } state_e;

  state_e                 state;
  state_e                 state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   released;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_next;
  logic                   req_armed;
  logic                   req_armed_next;
  logic                   member_reset_next;
  logic                   reset_done_next;
  logic                   ack_next;

  // The member clock is the group clock. It is neither gated nor buffered
  // through any logic here.
  assign auto_out_member_0_clock = clock;

  // -------------------------------------------------------------------------
  // Reset-release synchronizer. All stages clear as soon as reset is asserted.
  // After release, a 1 walks through the chain. The release therefore reaches
  // the FSM only after SYNC_STAGES clean clock edges.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples pre-edge values, which keeps the shift chain from collapsing
      // into a single stage.
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign released = sync[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // State register. These flops also see the raw reset release. That is
  // harmless, because HOLD cannot be left until the synchronizer output
  // rises. On the release edge itself, none of these flops can change value.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= HOLD;
      count                   <= '0;
      req_armed               <= 1'b1;
      auto_out_member_0_reset <= 1'b1;
      reset_done              <= 1'b0;
      sw_reset_ack            <= 1'b0;
    end else begin
      state                   <= state_next;
      count                   <= count_next;
      req_armed               <= req_armed_next;
      auto_out_member_0_reset <= member_reset_next;
      reset_done              <= reset_done_next;
      sw_reset_ack            <= ack_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement. An
    // unassigned path would otherwise infer a latch.
    state_next     = state;
    count_next     = count;
    req_armed_next = req_armed;

    // A request re-arms only after it has been seen low. A request held high
    // for any length of time therefore produces a single software reset.
    // Re-arming happens in every state, including those that ignore the
    // request.
    if (!sw_reset_req) begin
      req_armed_next = 1'b1;
    end

    case (state)
      HOLD: begin
        if (released) begin
          state_next = STRETCH;
          count_next = '0;
        end
      end
      STRETCH, SWRST: begin
        // The counter stops at its last value instead of wrapping. It is
        // reloaded whenever a counting state is entered.
        if (count == CNT_LAST) begin
          state_next = RUN;
        end else begin
          count_next = count + 1'b1;
        end
      end
      RUN: begin
        if (sw_reset_req && req_armed) begin
          state_next     = SWRST;
          count_next     = '0;
          req_armed_next = 1'b0;
        end
      end
      default: begin
        state_next = HOLD;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. The outputs are computed from the next state and then
  // registered. They change on the same edge as the state, and every output
  // leaves through a flop.
  // -------------------------------------------------------------------------
  always_comb begin
    member_reset_next = (state_next != RUN);
    reset_done_next   = (state_next == RUN);
    ack_next          = (state == SWRST) && (state_next == RUN);
  end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_clock_group_reset_sequencer
//
// Drives two instances from a single clock and reset:
//   dut1 uses the default parameters (3 sync stages, 16 stretch cycles);
//   dut2 uses SYNC_STAGES=2 and STRETCH_CYCLES=1.
// Each stimulus step pushes the output events it expects (member-reset rise,
// member-reset fall, ack high) with the absolute clock-edge number at which
// each event must appear. A monitor samples on every falling clock edge,
// detects events, and pops the queue to compare them.
// ---------------------------------------------------------------------------
module tb_clock_group_reset_sequencer;

  typedef enum int {EV_RISE, EV_FALL, EV_ACK} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       at_edge;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sw_reset_req = 1'b0;
  logic req2 = 1'b0;

  logic ack1, mclk1, mr1, done1;
  logic ack2, mclk2, mr2, done2;

  int   edge_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  ev_t  q1[$];
  ev_t  q2[$];
  logic prev1 = 1'b1;
  logic prev2 = 1'b1;

  clock_group_reset_sequencer #(.SYNC_STAGES(3), .STRETCH_CYCLES(16)) dut1 (
    .clock                   (clock),
    .reset                   (reset),
    .sw_reset_req            (sw_reset_req),
    .sw_reset_ack            (ack1),
    .auto_out_member_0_clock (mclk1),
    .auto_out_member_0_reset (mr1),
    .reset_done              (done1)
  );

  clock_group_reset_sequencer #(.SYNC_STAGES(2), .STRETCH_CYCLES(1)) dut2 (
    .clock                   (clock),
    .reset                   (reset),
    .sw_reset_req            (req2),
    .sw_reset_ack            (ack2),
    .auto_out_member_0_clock (mclk2),
    .auto_out_member_0_reset (mr2),
    .reset_done              (done2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp_v, edge_n);
    end
  endtask

  task automatic exp1(input ev_kind_e k, input int e);
    ev_t x;
    x.kind    = k;
    x.at_edge = e;
    q1.push_back(x);
  endtask

  task automatic exp2(input ev_kind_e k, input int e);
    ev_t x;
    x.kind    = k;
    x.at_edge = e;
    q2.push_back(x);
  endtask

  // Pops the next expected event for one instance and compares it with the
  // event just observed.
  task automatic take(input int which, input ev_kind_e kind);
    ev_t e;
    int  sz;
    sz = (which == 1) ? q1.size() : q2.size();
    n_checks++;
    if (sz == 0) begin
      n_fail++;
      $display("FAIL dut%0d unexpected event: got %s at edge %0d, expected none",
               which, kind.name(), edge_n);
    end else begin
      e = (which == 1) ? q1.pop_front() : q2.pop_front();
      if (e.kind != kind || e.at_edge != edge_n) begin
        n_fail++;
        $display("FAIL dut%0d event: got %s at edge %0d, expected %s at edge %0d",
                 which, kind.name(), edge_n, e.kind.name(), e.at_edge);
      end
    end
  endtask

  // Monitor: samples half a cycle after each active edge.
  always @(negedge clock) begin
    if (prev1 && !mr1) take(1, EV_FALL);
    if (!prev1 && mr1) take(1, EV_RISE);
    if (ack1)          take(1, EV_ACK);
    if (prev2 && !mr2) take(2, EV_FALL);
    if (!prev2 && mr2) take(2, EV_RISE);
    if (ack2)          take(2, EV_ACK);
    check("dut1 reset_done vs member reset", done1, !mr1);
    check("dut2 reset_done vs member reset", done2, !mr2);
    prev1 <= mr1;
    prev2 <= mr2;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Asserts reset just after a rising edge. An asynchronous member reset
  // must already be visible at the following falling edge.
  task automatic async_assert;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("dut1 async member reset", mr1, 1);
    check("dut2 async member reset", mr2, 1);
  endtask

  initial begin
    int rel;
    int e;
    // Reset state.
    #1 reset = 1'b0;
    #1;
    check("dut1 reset member_reset", mr1, 1);
    check("dut1 reset reset_done", done1, 0);
    check("dut1 reset sw_reset_ack", ack1, 0);
    check("dut2 reset member_reset", mr2, 1);
    check("dut2 reset reset_done", done2, 0);
    check("dut1 member clock low", mclk1, clock);
    check("dut2 member clock low", mclk2, clock);

    // Power-on: hold reset for 5 cycles, then release.
    wait_neg(5);
    rel = edge_n;
    reset = 1'b1;
    exp1(EV_FALL, rel + 20);
    exp2(EV_FALL, rel + 4);
    @(posedge clock);
    #1;
    check("dut1 member clock high", mclk1, clock);
    wait_neg(24);

    // Single-cycle software reset request.
    e = edge_n;
    sw_reset_req = 1'b1;
    exp1(EV_RISE, e + 1);
    exp1(EV_FALL, e + 17);
    exp1(EV_ACK,  e + 17);
    wait_neg(1);
    sw_reset_req = 1'b0;
    wait_neg(20);

    // Request held for 100 cycles yields one SWRST. Drop it, then reassert.
    e = edge_n;
    sw_reset_req = 1'b1;
    exp1(EV_RISE, e + 1);
    exp1(EV_FALL, e + 17);
    exp1(EV_ACK,  e + 17);
    wait_neg(100);
    sw_reset_req = 1'b0;
    wait_neg(5);
    e = edge_n;
    sw_reset_req = 1'b1;
    exp1(EV_RISE, e + 1);
    exp1(EV_FALL, e + 17);
    exp1(EV_ACK,  e + 17);
    wait_neg(1);
    sw_reset_req = 1'b0;
    wait_neg(20);

    // Asynchronous reset in RUN, then a request pulsed at STRETCH counter=3.
    async_assert();
    exp1(EV_RISE, edge_n);
    exp2(EV_RISE, edge_n);
    wait_neg(4);
    rel = edge_n;
    reset = 1'b1;
    exp1(EV_FALL, rel + 20);
    exp2(EV_FALL, rel + 4);
    wait_neg(7);                 // edge rel+7: dut1 counter == 3
    sw_reset_req = 1'b1;
    wait_neg(1);
    sw_reset_req = 1'b0;
    wait_neg(17);

    // Reset again, then assert reset mid-STRETCH at counter=7. The full
    // sequence must restart after release.
    async_assert();
    exp1(EV_RISE, edge_n);
    exp2(EV_RISE, edge_n);
    wait_neg(3);
    rel = edge_n;
    reset = 1'b1;
    exp2(EV_FALL, rel + 4);
    wait_neg(10);                // edge rel+10; next edge loads counter 7
    @(posedge clock);
    #1;
    reset = 1'b0;                // dut1 is in STRETCH with counter == 7
    #1;
    check("dut1 member reset mid-stretch", mr1, 1);
    check("dut1 reset_done mid-stretch", done1, 0);
    exp2(EV_RISE, edge_n);
    wait_neg(3);
    rel = edge_n;
    reset = 1'b1;
    exp1(EV_FALL, rel + 20);
    exp2(EV_FALL, rel + 4);
    wait_neg(28);

    check("dut1 pending events", q1.size(), 0);
    check("dut2 pending events", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clock_group_reset_sequencer.md
CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 3, number of reset-deassertion synchronizer flops (legal 2..8).
REQ-002 SHALL provide parameter STRETCH_CYCLES, default 16, cycles of output reset held after synchronized release (legal 1..1024).
REQ-003 SHALL provide port clock  input  1  the single clock for all flops; also the source of the member clock.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 SHALL provide port sw_reset_req  input  1  level request for a software-initiated member reset.
REQ-006 SHALL provide port sw_reset_ack  output  1  one-cycle pulse when a software reset has completed.
REQ-007 SHALL provide port auto_out_member_0_clock  output  1  member clock, driven by clock.
REQ-008 SHALL provide port auto_out_member_0_reset  output  1  member reset, active-high, for the clock-group aggregator.
REQ-009 SHALL provide port reset_done  output  1  high when state is RUN.

Function
REQ-010 SHALL assign auto_out_member_0_clock directly from clock, with no gating or logic.
REQ-011 SHALL implement a SYNC_STAGES-deep synchronizer: all stages clear asynchronously on reset=0; stage 0 loads 1, others shift, once reset=1.
REQ-012 SHALL implement states HOLD, STRETCH, RUN, SWRST in a state register.
REQ-013 HOLD -> STRETCH on the first rising edge at which the last synchronizer stage is 1; counter loads 0.
REQ-014 STRETCH: counter increments each cycle; -> RUN on the edge where counter == STRETCH_CYCLES-1.
REQ-015 RUN -> SWRST on an edge where sw_reset_req=1 and req_armed=1; counter loads 0, req_armed clears.
REQ-016 SWRST: counter increments; -> RUN on the edge where counter == STRETCH_CYCLES-1; sw_reset_ack=1 for exactly the first RUN cycle.
REQ-017 req_armed SHALL set on any edge where sw_reset_req=0 and reset to 1; one request yields one SWRST regardless of hold time.
REQ-018 Counter width SHALL be ceil(log2(STRETCH_CYCLES+1)); counter never wraps, it is reloaded on state entry.
REQ-019 auto_out_member_0_reset SHALL be a flop: 1 in HOLD/STRETCH/SWRST, 0 in RUN, updated on the same edge as the state.
REQ-020 reset_done SHALL be a flop equal to (next state == RUN); sw_reset_ack SHALL be a flop, never combinational.
REQ-021 sw_reset_req in HOLD, STRETCH or SWRST SHALL be ignored, but still updates req_armed.
REQ-022 Member reset low after release SHALL occur exactly SYNC_STAGES+STRETCH_CYCLES+1 edges after reset deasserts (20 with defaults).

Reset
REQ-023 On reset=0, asynchronously: synchronizer=0, state=HOLD, counter=0, auto_out_member_0_reset=1, reset_done=0, sw_reset_ack=0, req_armed=1.
REQ-024 Reset assertion in any state, including mid-STRETCH or mid-SWRST, SHALL force member reset to 1 without waiting for a clock edge.
REQ-025 Reset deassertion SHALL affect outputs only through the synchronizer path, never asynchronously.

Verification
REQ-026 Power-on: reset=0 for 5 cycles, then 1 -> auto_out_member_0_reset stays 1 until edge 20, then 0; reset_done rises on the same edge.
REQ-027 SW reset: in RUN, sw_reset_req=1 for 1 cycle -> member reset 1 for 16 cycles, then 0; sw_reset_ack high exactly 1 cycle.
REQ-028 Held request: sw_reset_req held 100 cycles -> exactly one SWRST and one ack; drop, then reassert -> second SWRST.
REQ-029 Mid-sequence reset: reset=0 at STRETCH counter=7 -> member reset 1 immediately; after release, full 20-edge sequence restarts.
REQ-030 Request during STRETCH: sw_reset_req pulsed at counter=3 -> no extra SWRST; RUN reached at the normal edge.
REQ-031 Parameter sweep: SYNC_STAGES=2, STRETCH_CYCLES=1 -> member reset deasserts 4 edges after release.
